stage_mem_pipelined: RTL and testbench

Pipelined memory stage front-end replacing the single-request MEM1 LSU handshake. It accepts load/store operations from EX, formats store data and byte enables, and issues them on a req/gnt memory bus with up to `MAX_OUTSTANDING` requests in flight. It tracks in-flight operations in an in-order queue and returns formatted, sign/zero-extended load data or a trap to the MEM2/WB side. Misaligned accesses and bus errors are converted into precise, in-order traps.

---
 rtl/stage_mem_pipelined_if.sv | 54 +++++
 rtl/stage_mem_pipelined.sv | 260 ++++++++++++++++++++++++++
 tb/tb_stage_mem_pipelined.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_mem_pipelined_if.sv
// ============================================================================
// stage_mem_pipelined_if : op/trap types and the req/gnt memory bus bundle
// Rev 1.0
// ============================================================================
`default_nettype none

package stage_mem_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_oper_t;

  // Non-zero codes follow the RISC-V mcause numbering.
  typedef enum logic [3:0] {
    NO_TRAP               = 4'd0,
    LOAD_ADDR_MISALIGNED  = 4'd4,
    LOAD_ACCESS_FAULT     = 4'd5,
    STORE_ADDR_MISALIGNED = 4'd6,
    STORE_ACCESS_FAULT    = 4'd7
  } exc_t;

endpackage

interface stage_mem_pipelined_if;
  logic        bus_req_o;
  logic        bus_gnt_i;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;

  modport master (
    output bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
  );

  modport slave (
    input  bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
  );
endinterface

`default_nettype wire

// File: rtl/stage_mem_pipelined.sv
// ============================================================================
// stage_mem_pipelined : pipelined LSU front-end, req/gnt bus, in-order retire
// Rev 1.0
// ============================================================================
`default_nettype none

module stage_mem_pipelined
  import stage_mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit CHECK_ALIGN     = 1'b1
) (
  input  wire logic              clk_i,
  input  wire logic              rstn_i,
  input  wire logic              req_valid_i,
  input  wire mem_oper_t         mem_oper_i,
  input  wire logic [31:0]       addr_i,
  input  wire logic [31:0]       wdata_i,
  input  wire logic [4:0]        rd_addr_i,
  output logic                   req_ready_o,
  input  wire logic              flush_i,
  stage_mem_pipelined_if.master  bus,
  output logic                   rsp_valid_o,
  output logic                   rsp_is_load_o,
  output logic [4:0]             rsp_rd_addr_o,
  output logic [31:0]            rsp_rdata_o,
  output exc_t                   rsp_trap_o,
  output logic                   busy_o
);

  localparam int c_cnt_w = 3;
  typedef logic [c_cnt_w-1:0] cnt_t;
  localparam cnt_t c_max = cnt_t'(MAX_OUTSTANDING);

  typedef struct packed {
    mem_oper_t   op;
    logic [1:0]  off;
    logic [4:0]  rd;
    exc_t        trap;
    logic        granted;
    logic        killed;
  } entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  function automatic logic f_is_load(input mem_oper_t op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic f_is_store(input mem_oper_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  state_t      r_state, w_state_n;
  entry_t      r_q   [MAX_OUTSTANDING];
  entry_t      w_q_n [MAX_OUTSTANDING];
  entry_t      w_stage [MAX_OUTSTANDING];
  cnt_t        r_count, w_count_n, w_cnt_tmp;

  logic [31:0] r_bus_addr, r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic        r_bus_we;

  logic        w_req_ready, w_accept, w_issue, w_misalign, w_is_store;
  exc_t        w_new_trap;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  entry_t      w_new_entry;

  entry_t      w_head;
  logic        w_head_load, w_head_trap, w_retire, w_rsp_fire;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldata, w_rsp_data;
  exc_t        w_rsp_trap;

  // ---------------------------------------------------------------- accept
  assign w_req_ready = ((r_state == IDLE) || bus.bus_gnt_i) && (r_count < c_max) && !flush_i;
  assign w_accept    = req_valid_i && w_req_ready && (mem_oper_i != MEM_NOP);
  assign w_issue     = w_accept && !w_misalign;
  assign w_is_store  = f_is_store(mem_oper_i);

  always_comb begin
    w_misalign = 1'b0;
    if (CHECK_ALIGN) begin
      unique case (mem_oper_i)
        MEM_LH, MEM_LHU, MEM_SH: w_misalign = addr_i[0];
        MEM_LW, MEM_SW:          w_misalign = |addr_i[1:0];
        default:                 w_misalign = 1'b0;
      endcase
    end
    w_new_trap = NO_TRAP;
    if (w_misalign) w_new_trap = w_is_store ? STORE_ADDR_MISALIGNED : LOAD_ADDR_MISALIGNED;
  end

  // Store data is shifted onto its byte lanes; loads read the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    unique case (mem_oper_i)
      MEM_SB: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = wdata_i << {addr_i[1:0], 3'b000};
      end
      MEM_SH: begin
        w_be    = 4'b0011 << {addr_i[1], 1'b0};
        w_wdata = wdata_i << {addr_i[1], 4'b0000};
      end
      MEM_SW:  w_wdata = wdata_i;
      default: w_wdata = '0;
    endcase
  end

  assign w_new_entry = '{op: mem_oper_i, off: addr_i[1:0], rd: rd_addr_i,
                         trap: w_new_trap, granted: 1'b0, killed: 1'b0};

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= IDLE;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE: if (w_issue) w_state_n = REQ;
      REQ: begin
        if (flush_i)             w_state_n = IDLE;
        else if (bus.bus_gnt_i)  w_state_n = w_issue ? REQ : IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_bus_addr  <= '0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
    end else if (w_issue) begin
      r_bus_addr  <= {addr_i[31:2], 2'b00};
      r_bus_we    <= w_is_store;
      r_bus_be    <= w_be;
      r_bus_wdata <= w_wdata;
    end
  end

  assign bus.bus_req_o   = (r_state == REQ);
  assign bus.bus_addr_o  = r_bus_addr;
  assign bus.bus_we_o    = r_bus_we;
  assign bus.bus_be_o    = r_bus_be;
  assign bus.bus_wdata_o = r_bus_wdata;

  // ---------------------------------------------------------------- retire
  assign w_head      = r_q[0];
  assign w_head_load = f_is_load(w_head.op);
  assign w_head_trap = (w_head.trap != NO_TRAP);
  assign w_retire    = (r_count != '0) && (w_head_trap || (w_head.granted && bus.bus_rvalid_i));
  assign w_rsp_fire  = w_retire && !w_head.killed && !flush_i;

  assign w_byte = 8'(bus.bus_rdata_i >> {w_head.off, 3'b000});
  assign w_half = w_head.off[1] ? bus.bus_rdata_i[31:16] : bus.bus_rdata_i[15:0];

  always_comb begin
    w_ldata = '0;
    unique case (w_head.op)
      MEM_LB:  w_ldata = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: w_ldata = {24'd0, w_byte};
      MEM_LH:  w_ldata = {{16{w_half[15]}}, w_half};
      MEM_LHU: w_ldata = {16'd0, w_half};
      MEM_LW:  w_ldata = bus.bus_rdata_i;
      default: w_ldata = '0;
    endcase
    w_rsp_trap = NO_TRAP;
    if (w_head_trap)        w_rsp_trap = w_head.trap;
    else if (bus.bus_err_i) w_rsp_trap = w_head_load ? LOAD_ACCESS_FAULT : STORE_ACCESS_FAULT;
    w_rsp_data = (w_head_load && (w_rsp_trap == NO_TRAP)) ? w_ldata : '0;
  end

  // ----------------------------------------------------------------- queue
  // Head lives in slot 0. A flush keeps only granted entries (their
  // responses are still owed by the bus) and compacts them toward the head.
  always_comb begin : p_queue_next
    int k;
    k = 0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) w_stage[i] = r_q[i];
    if ((r_state == REQ) && bus.bus_gnt_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        if (r_count == cnt_t'(i + 1)) w_stage[i].granted = 1'b1;
    end
    w_cnt_tmp = r_count;
    if (w_retire) begin
      for (int i = 0; i < MAX_OUTSTANDING - 1; i++) w_stage[i] = w_stage[i + 1];
      w_cnt_tmp = r_count - cnt_t'(1);
    end
    for (int i = 0; i < MAX_OUTSTANDING; i++) w_q_n[i] = w_stage[i];
    w_count_n = w_cnt_tmp;
    if (flush_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if ((cnt_t'(i) < w_cnt_tmp) && w_stage[i].granted) begin
          for (int j = 0; j < MAX_OUTSTANDING; j++) begin
            if (j == k) begin
              w_q_n[j]        = w_stage[i];
              w_q_n[j].killed = 1'b1;
            end
          end
          k = k + 1;
        end
      end
      w_count_n = cnt_t'(k);
    end else if (w_accept) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        if (cnt_t'(i) == w_cnt_tmp) w_q_n[i] = w_new_entry;
      w_count_n = w_cnt_tmp + cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_count <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_q[i] <= '0;
    end else begin
      r_count <= w_count_n;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_q[i] <= w_q_n[i];
    end
  end

  // -------------------------------------------------------------- response
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_valid_o   <= 1'b0;
      rsp_is_load_o <= 1'b0;
      rsp_rd_addr_o <= '0;
      rsp_rdata_o   <= '0;
      rsp_trap_o    <= NO_TRAP;
    end else if (w_rsp_fire) begin
      rsp_valid_o   <= 1'b1;
      rsp_is_load_o <= w_head_load;
      rsp_rd_addr_o <= w_head_load ? w_head.rd : 5'd0;
      rsp_rdata_o   <= w_rsp_data;
      rsp_trap_o    <= w_rsp_trap;
    end else begin
      rsp_valid_o   <= 1'b0;
      rsp_is_load_o <= 1'b0;
      rsp_rd_addr_o <= '0;
      rsp_rdata_o   <= '0;
      rsp_trap_o    <= NO_TRAP;
    end
  end

  assign req_ready_o = w_req_ready;
  assign busy_o      = (r_count != '0) || (r_state == REQ);

endmodule

`default_nettype wire

// File: tb/tb_stage_mem_pipelined.sv
// ============================================================================
// tb_stage_mem_pipelined : directed self-checking bench, depth-2 and depth-3
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stage_mem_pipelined;
  import stage_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  mem_oper_t   mem_oper = MEM_NOP;
  logic [31:0] addr = '0, wdata = '0;
  logic [4:0]  rd_addr = '0;
  logic        flush = 1'b0;
  logic        gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
  logic [31:0] rdata = '0;

  logic        ready_a, rsp_valid_a, rsp_is_load_a, busy_a;
  logic [4:0]  rsp_rd_a;
  logic [31:0] rsp_rdata_a;
  exc_t        rsp_trap_a;
  logic        ready_b, rsp_valid_b, rsp_is_load_b, busy_b;
  logic [4:0]  rsp_rd_b;
  logic [31:0] rsp_rdata_b;
  exc_t        rsp_trap_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic        cap_ready, cap_req, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  stage_mem_pipelined_if bus_a ();
  stage_mem_pipelined_if bus_b ();

  assign bus_a.bus_gnt_i    = gnt;
  assign bus_a.bus_rvalid_i = rvalid;
  assign bus_a.bus_rdata_i  = rdata;
  assign bus_a.bus_err_i    = err;
  assign bus_b.bus_gnt_i    = gnt;
  assign bus_b.bus_rvalid_i = rvalid;
  assign bus_b.bus_rdata_i  = rdata;
  assign bus_b.bus_err_i    = err;

  stage_mem_pipelined #(.MAX_OUTSTANDING(2), .CHECK_ALIGN(1'b1)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid), .mem_oper_i(mem_oper),
    .addr_i(addr), .wdata_i(wdata), .rd_addr_i(rd_addr), .req_ready_o(ready_a),
    .flush_i(flush), .bus(bus_a), .rsp_valid_o(rsp_valid_a), .rsp_is_load_o(rsp_is_load_a),
    .rsp_rd_addr_o(rsp_rd_a), .rsp_rdata_o(rsp_rdata_a), .rsp_trap_o(rsp_trap_a), .busy_o(busy_a)
  );

  stage_mem_pipelined #(.MAX_OUTSTANDING(3), .CHECK_ALIGN(1'b1)) u_dut3 (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid), .mem_oper_i(mem_oper),
    .addr_i(addr), .wdata_i(wdata), .rd_addr_i(rd_addr), .req_ready_o(ready_b),
    .flush_i(flush), .bus(bus_b), .rsp_valid_o(rsp_valid_b), .rsp_is_load_o(rsp_is_load_b),
    .rsp_rd_addr_o(rsp_rd_b), .rsp_rdata_o(rsp_rdata_b), .rsp_trap_o(rsp_trap_b), .busy_o(busy_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; mem_oper = MEM_NOP; addr = '0; wdata = '0; rd_addr = '0;
    flush = 1'b0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  // Accept -> grant on the first request cycle -> response the cycle after.
  // Returns in the cycle where the registered response is visible.
  task automatic run_single(input mem_oper_t op, input logic [31:0] a, input logic [31:0] wd,
                            input logic [4:0] rd, input logic [31:0] rdat, input logic e);
    req_valid = 1'b1; mem_oper = op; addr = a; wdata = wd; rd_addr = rd;
    #1 cap_ready = ready_a;
    tick();
    req_valid = 1'b0;
    cap_req = bus_a.bus_req_o; cap_addr = bus_a.bus_addr_o; cap_be = bus_a.bus_be_o;
    cap_we = bus_a.bus_we_o; cap_wdata = bus_a.bus_wdata_o;
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = rdat; err = e;
    tick();
    rvalid = 1'b0; err = 1'b0;
  endtask

  task automatic test_reset();
    logic [113:0] got;
    idle_inputs();
    rstn = 1'b0;
    tick();
    got = {bus_a.bus_req_o, bus_a.bus_we_o, bus_a.bus_be_o, bus_a.bus_addr_o, bus_a.bus_wdata_o,
           rsp_valid_a, rsp_is_load_a, rsp_rd_a, rsp_rdata_a, rsp_trap_a, busy_a};
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_values: got %h required 0", got); end
    rstn = 1'b1;
    tick();
    n_checks++;
    if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", ready_a); end
  endtask

  task automatic test_lw();
    apply_reset();
    run_single(MEM_LW, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 1'b0);
    n_checks++;
    if (cap_ready !== 1'b1) begin n_fail++; $display("FAIL lw_ready: got %b required 1", cap_ready); end
    n_checks++;
    if ({cap_req, cap_we, cap_be, cap_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      n_fail++; $display("FAIL lw_bus: got req/we/be/addr %b/%b/%h/%h required 1/0/f/00000100",
                         cap_req, cap_we, cap_be, cap_addr);
    end
    n_checks++;
    if ({rsp_valid_a, rsp_is_load_a, rsp_rd_a, rsp_rdata_a, rsp_trap_a} !==
        {1'b1, 1'b1, 5'd5, 32'hDEADBEEF, NO_TRAP}) begin
      n_fail++; $display("FAIL lw_rsp: got v/ld/rd/data/trap %b/%b/%0d/%h/%0d required 1/1/5/deadbeef/0",
                         rsp_valid_a, rsp_is_load_a, rsp_rd_a, rsp_rdata_a, rsp_trap_a);
    end
    tick();
    n_checks++;
    if ({rsp_valid_a, busy_a} !== 2'b00) begin
      n_fail++; $display("FAIL lw_pulse_end: got valid/busy %b/%b required 0/0", rsp_valid_a, busy_a);
    end
  endtask

  task automatic test_store_format_and_extend();
    apply_reset();
    run_single(MEM_SB, 32'h203, 32'h000000A5, 5'd0, 32'h0, 1'b0);
    n_checks++;
    if ({cap_we, cap_be, cap_wdata, cap_addr} !== {1'b1, 4'b1000, 32'hA5000000, 32'h200}) begin
      n_fail++; $display("FAIL sb_bus: got we/be/wdata/addr %b/%b/%h/%h required 1/1000/a5000000/00000200",
                         cap_we, cap_be, cap_wdata, cap_addr);
    end
    n_checks++;
    if ({rsp_valid_a, rsp_is_load_a, rsp_rdata_a, rsp_trap_a} !== {1'b1, 1'b0, 32'h0, NO_TRAP}) begin
      n_fail++; $display("FAIL sb_rsp: got v/ld/data/trap %b/%b/%h/%0d required 1/0/0/0",
                         rsp_valid_a, rsp_is_load_a, rsp_rdata_a, rsp_trap_a);
    end
    run_single(MEM_SH, 32'h202, 32'h0000BEEF, 5'd0, 32'h0, 1'b0);
    n_checks++;
    if ({cap_be, cap_wdata} !== {4'b1100, 32'hBEEF0000}) begin
      n_fail++; $display("FAIL sh_bus: got be/wdata %b/%h required 1100/beef0000", cap_be, cap_wdata);
    end
    run_single(MEM_LB, 32'h203, 32'h0, 5'd7, 32'hA5000000, 1'b0);
    n_checks++;
    if ({cap_be, cap_we} !== {4'hF, 1'b0}) begin
      n_fail++; $display("FAIL lb_bus: got be/we %b/%b required 1111/0", cap_be, cap_we);
    end
    n_checks++;
    if ({rsp_rdata_a, rsp_rd_a} !== {32'hFFFFFFA5, 5'd7}) begin
      n_fail++; $display("FAIL lb_rsp: got data/rd %h/%0d required ffffffa5/7", rsp_rdata_a, rsp_rd_a);
    end
    run_single(MEM_LBU, 32'h203, 32'h0, 5'd7, 32'hA5000000, 1'b0);
    n_checks++;
    if (rsp_rdata_a !== 32'h000000A5) begin
      n_fail++; $display("FAIL lbu_rsp: got %h required 000000a5", rsp_rdata_a);
    end
    run_single(MEM_LH, 32'h102, 32'h0, 5'd8, 32'h80001234, 1'b0);
    n_checks++;
    if (rsp_rdata_a !== 32'hFFFF8000) begin
      n_fail++; $display("FAIL lh_rsp: got %h required ffff8000", rsp_rdata_a);
    end
    run_single(MEM_LHU, 32'h102, 32'h0, 5'd8, 32'h80001234, 1'b0);
    n_checks++;
    if (rsp_rdata_a !== 32'h00008000) begin
      n_fail++; $display("FAIL lhu_rsp: got %h required 00008000", rsp_rdata_a);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req_valid = 1'b1; mem_oper = MEM_LW; addr = 32'h10; rd_addr = 5'd1;
    tick();
    addr = 32'h14; rd_addr = 5'd2; gnt = 1'b1;
    #1;
    n_checks++;
    if (ready_a !== 1'b1) begin n_fail++; $display("FAIL b2b_grant_ready: got %b required 1", ready_a); end
    tick();
    n_checks++;
    if ({bus_a.bus_req_o, bus_a.bus_addr_o} !== {1'b1, 32'h14}) begin
      n_fail++; $display("FAIL b2b_second_req: got req/addr %b/%h required 1/00000014",
                         bus_a.bus_req_o, bus_a.bus_addr_o);
    end
    addr = 32'h18; rd_addr = 5'd3;
    #1;
    n_checks++;
    if (ready_a !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got ready %b required 0", ready_a); end
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'hAAAA0000;
    #1;
    n_checks++;
    if ({ready_a, bus_a.bus_req_o} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_still_full: got ready/req %b/%b required 0/0", ready_a, bus_a.bus_req_o);
    end
    tick();
    rvalid = 1'b0;
    n_checks++;
    if ({rsp_valid_a, rsp_rdata_a, ready_a} !== {1'b1, 32'hAAAA0000, 1'b1}) begin
      n_fail++; $display("FAIL b2b_rsp0: got v/data/ready %b/%h/%b required 1/aaaa0000/1",
                         rsp_valid_a, rsp_rdata_a, ready_a);
    end
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({bus_a.bus_req_o, bus_a.bus_addr_o} !== {1'b1, 32'h18}) begin
      n_fail++; $display("FAIL b2b_third_req: got req/addr %b/%h required 1/00000018",
                         bus_a.bus_req_o, bus_a.bus_addr_o);
    end
    gnt = 1'b1; rvalid = 1'b1; rdata = 32'hBBBB1111;
    tick();
    gnt = 1'b0; rdata = 32'hCCCC2222;
    n_checks++;
    if ({rsp_valid_a, rsp_rdata_a, rsp_rd_a} !== {1'b1, 32'hBBBB1111, 5'd2}) begin
      n_fail++; $display("FAIL b2b_rsp1: got v/data/rd %b/%h/%0d required 1/bbbb1111/2",
                         rsp_valid_a, rsp_rdata_a, rsp_rd_a);
    end
    tick();
    rvalid = 1'b0;
    n_checks++;
    if ({rsp_valid_a, rsp_rdata_a, rsp_rd_a} !== {1'b1, 32'hCCCC2222, 5'd3}) begin
      n_fail++; $display("FAIL b2b_rsp2: got v/data/rd %b/%h/%0d required 1/cccc2222/3",
                         rsp_valid_a, rsp_rdata_a, rsp_rd_a);
    end
    tick();
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got busy %b required 0", busy_a); end
  endtask

  task automatic test_misaligned();
    apply_reset();
    req_valid = 1'b1; mem_oper = MEM_LH; addr = 32'h101; rd_addr = 5'd3;
    tick();
    mem_oper = MEM_LW; addr = 32'h104; rd_addr = 5'd4;
    n_checks++;
    if ({bus_a.bus_req_o, busy_a} !== 2'b01) begin
      n_fail++; $display("FAIL mis_no_req: got req/busy %b/%b required 0/1", bus_a.bus_req_o, busy_a);
    end
    tick();
    req_valid = 1'b0; gnt = 1'b1;
    n_checks++;
    if ({rsp_valid_a, rsp_is_load_a, rsp_rdata_a, rsp_trap_a} !== {1'b1, 1'b1, 32'h0, LOAD_ADDR_MISALIGNED}) begin
      n_fail++; $display("FAIL mis_trap_rsp: got v/ld/data/trap %b/%b/%h/%0d required 1/1/0/4",
                         rsp_valid_a, rsp_is_load_a, rsp_rdata_a, rsp_trap_a);
    end
    n_checks++;
    if ({bus_a.bus_req_o, bus_a.bus_addr_o} !== {1'b1, 32'h104}) begin
      n_fail++; $display("FAIL mis_lw_req: got req/addr %b/%h required 1/00000104",
                         bus_a.bus_req_o, bus_a.bus_addr_o);
    end
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h12345678;
    n_checks++;
    if (rsp_valid_a !== 1'b0) begin n_fail++; $display("FAIL mis_gap: got valid %b required 0", rsp_valid_a); end
    tick();
    rvalid = 1'b0;
    n_checks++;
    if ({rsp_valid_a, rsp_rdata_a, rsp_trap_a, rsp_rd_a} !== {1'b1, 32'h12345678, NO_TRAP, 5'd4}) begin
      n_fail++; $display("FAIL mis_lw_rsp: got v/data/trap/rd %b/%h/%0d/%0d required 1/12345678/0/4",
                         rsp_valid_a, rsp_rdata_a, rsp_trap_a, rsp_rd_a);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    req_valid = 1'b1; mem_oper = MEM_LW; addr = 32'h20; rd_addr = 5'd1;
    tick();
    addr = 32'h24; rd_addr = 5'd2; gnt = 1'b1;
    tick();
    addr = 32'h28; rd_addr = 5'd3;
    tick();
    req_valid = 1'b0; gnt = 1'b0;
    n_checks++;
    if ({bus_b.bus_req_o, bus_b.bus_addr_o} !== {1'b1, 32'h28}) begin
      n_fail++; $display("FAIL flush_pending: got req/addr %b/%h required 1/00000028",
                         bus_b.bus_req_o, bus_b.bus_addr_o);
    end
    flush = 1'b1;
    #1;
    n_checks++;
    if (ready_b !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got ready %b required 0", ready_b); end
    tick();
    flush = 1'b0; rvalid = 1'b1; rdata = 32'h11111111;
    n_checks++;
    if ({bus_b.bus_req_o, busy_b} !== 2'b01) begin
      n_fail++; $display("FAIL flush_drop: got req/busy %b/%b required 0/1", bus_b.bus_req_o, busy_b);
    end
    tick();
    rdata = 32'h22222222;
    n_checks++;
    if ({rsp_valid_b, busy_b} !== 2'b01) begin
      n_fail++; $display("FAIL flush_kill1: got valid/busy %b/%b required 0/1", rsp_valid_b, busy_b);
    end
    tick();
    rvalid = 1'b0;
    n_checks++;
    if ({rsp_valid_b, busy_b} !== 2'b00) begin
      n_fail++; $display("FAIL flush_kill2: got valid/busy %b/%b required 0/0", rsp_valid_b, busy_b);
    end
  endtask

  task automatic test_store_err();
    apply_reset();
    run_single(MEM_SW, 32'h300, 32'h11223344, 5'd0, 32'hFFFFFFFF, 1'b1);
    n_checks++;
    if ({cap_we, cap_be, cap_wdata} !== {1'b1, 4'hF, 32'h11223344}) begin
      n_fail++; $display("FAIL sw_bus: got we/be/wdata %b/%b/%h required 1/1111/11223344",
                         cap_we, cap_be, cap_wdata);
    end
    n_checks++;
    if ({rsp_valid_a, rsp_is_load_a, rsp_rdata_a, rsp_trap_a} !== {1'b1, 1'b0, 32'h0, STORE_ACCESS_FAULT}) begin
      n_fail++; $display("FAIL sw_err_rsp: got v/ld/data/trap %b/%b/%h/%0d required 1/0/0/7",
                         rsp_valid_a, rsp_is_load_a, rsp_rdata_a, rsp_trap_a);
    end
  endtask

  task automatic test_async_reset();
    logic [113:0] got;
    apply_reset();
    req_valid = 1'b1; mem_oper = MEM_LW; addr = 32'h400; rd_addr = 5'd9;
    tick();
    req_valid = 1'b0; gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'hCAFEF00D;
    req_valid = 1'b1; addr = 32'h404;
    tick();
    req_valid = 1'b0; rvalid = 1'b0;
    n_checks++;
    if ({rsp_valid_a, rsp_rdata_a, bus_a.bus_req_o, bus_a.bus_addr_o} !== {1'b1, 32'hCAFEF00D, 1'b1, 32'h404}) begin
      n_fail++; $display("FAIL arst_pre: got v/data/req/addr %b/%h/%b/%h required 1/cafef00d/1/00000404",
                         rsp_valid_a, rsp_rdata_a, bus_a.bus_req_o, bus_a.bus_addr_o);
    end
    #1 rstn = 1'b0;
    #1;
    got = {bus_a.bus_req_o, bus_a.bus_we_o, bus_a.bus_be_o, bus_a.bus_addr_o, bus_a.bus_wdata_o,
           rsp_valid_a, rsp_is_load_a, rsp_rd_a, rsp_rdata_a, rsp_trap_a, busy_a};
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL arst_values: got %h required 0", got); end
    tick();
    rstn = 1'b1;
    rvalid = 1'b1; rdata = 32'h55555555;
    tick();
    rvalid = 1'b0;
    n_checks++;
    if ({rsp_valid_a, busy_a} !== 2'b00) begin
      n_fail++; $display("FAIL arst_late_rsp: got valid/busy %b/%b required 0/0", rsp_valid_a, busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_store_format_and_extend();
    test_back_to_back();
    test_misaligned();
    test_flush();
    test_store_err();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
